// File: rtl/rgb2gray_pkg.sv
// ============================================================================
// Module   : rgb2gray_pkg
// Purpose  : Shared widths, BT.601 default weights and width helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rgb2gray_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_FRAC   = 8;
  localparam int unsigned DEF_COEF_R = 77;
  localparam int unsigned DEF_COEF_G = 150;
  localparam int unsigned DEF_COEF_B = 29;

  // Weights are at most 9 bits wide, so each product needs 9 extra bits.
  function automatic int unsigned prod_width(input int unsigned data_w);
    return data_w + 9;
  endfunction

  // Three products plus the rounding term need 2 more bits than one product.
  function automatic int unsigned sum_width(input int unsigned data_w);
    return data_w + 11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_weighted_sum.sv
// ============================================================================
// Module   : rgb_weighted_sum
// Purpose  : Registered channel products, then rounded, saturated luma sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_weighted_sum
  import rgb2gray_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC   = DEF_FRAC,
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic [DATA_W-1:0] y
);

  localparam int unsigned PROD_W = prod_width(DATA_W);
  localparam int unsigned SUM_W  = sum_width(DATA_W);

  localparam logic [PROD_W-1:0] C_COEF_R = PROD_W'(COEF_R);
  localparam logic [PROD_W-1:0] C_COEF_G = PROD_W'(COEF_G);
  localparam logic [PROD_W-1:0] C_COEF_B = PROD_W'(COEF_B);
  localparam logic [SUM_W-1:0]  C_ROUND  = SUM_W'(2 ** (FRAC - 1));
  localparam logic [SUM_W-1:0]  C_MAX    = SUM_W'((2 ** DATA_W) - 1);

  logic [PROD_W-1:0] r_prod_r;
  logic [PROD_W-1:0] r_prod_g;
  logic [PROD_W-1:0] r_prod_b;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_shift;

  // Products load only for valid pixels so idle-cycle inputs never reach y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
    end else if (en) begin
      r_prod_r <= C_COEF_R * PROD_W'(red);
      r_prod_g <= C_COEF_G * PROD_W'(green);
      r_prod_b <= C_COEF_B * PROD_W'(blue);
    end
  end

  always_comb begin
    w_sum   = SUM_W'(r_prod_r) + SUM_W'(r_prod_g) + SUM_W'(r_prod_b) + C_ROUND;
    w_shift = w_sum >> FRAC;
    y       = (w_shift > C_MAX) ? {DATA_W{1'b1}} : w_shift[DATA_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/rgb2gray.sv
// ============================================================================
// Module   : rgb2gray
// Purpose  : Two-stage streaming RGB to BT.601 luma converter, 1 pixel/clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb2gray
  import rgb2gray_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B,
  parameter int unsigned FRAC   = DEF_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] red_i,
  input  logic [DATA_W-1:0] green_i,
  input  logic [DATA_W-1:0] blue_i,
  input  logic              done_i,
  output logic [DATA_W-1:0] grayscale_o,
  output logic              done_o
);

  logic              r_v1;
  logic              r_done;
  logic [DATA_W-1:0] r_gray;
  logic [DATA_W-1:0] w_y;

  rgb_weighted_sum #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .COEF_R (COEF_R),
    .COEF_G (COEF_G),
    .COEF_B (COEF_B)
  ) u_weighted_sum (
    .clk   (clk),
    .rst   (rst),
    .en    (done_i),
    .red   (red_i),
    .green (green_i),
    .blue  (blue_i),
    .y     (w_y)
  );

  // The output register holds its value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_done <= 1'b0;
      r_gray <= '0;
    end else begin
      r_v1   <= done_i;
      r_done <= r_v1;
      if (r_v1) begin
        r_gray <= w_y;
      end
    end
  end

  assign grayscale_o = r_gray;
  assign done_o      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray.sv
// ============================================================================
// Module   : tb_rgb2gray
// Purpose  : Directed and golden-model checks of the rgb2gray pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rgb2gray;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] red_i = '0;
  logic [7:0] green_i = '0;
  logic [7:0] blue_i = '0;
  logic       done_i = 1'b0;
  logic [7:0] grayscale_o;
  logic       done_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rgb2gray dut (
    .clk         (clk),
    .rst         (rst),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .done_i      (done_i),
    .grayscale_o (grayscale_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Present one pixel, then land just after the sampling edge.
  task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    done_i  = v;
    red_i   = r;
    green_i = g;
    blue_i  = b;
    @(posedge clk);
    #1;
  endtask

  function automatic int golden(input int r, input int g, input int b);
    int s;
    s = (77 * r + 150 * g + 29 * b + 128) >> 8;
    if (s > 255) s = 255;
    return s;
  endfunction

  initial begin
    int r, g, b, prev;

    // Reset held with a valid white pixel on the inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'd255, 8'd255, 8'd255);
      check("rst_gray", 32'(grayscale_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
    end
    done_i = 1'b0;
    rst    = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("idle_done", 32'(done_o), 32'd0);

    // Primaries followed by grays, back-to-back
    drive(1'b1, 8'd255, 8'd0, 8'd0);
    check("first_lat_done", 32'(done_o), 32'd0);
    drive(1'b1, 8'd0, 8'd255, 8'd0);
    check("red_done", 32'(done_o), 32'd1);
    check("red_gray", 32'(grayscale_o), 32'd77);
    drive(1'b1, 8'd0, 8'd0, 8'd255);
    check("green_gray", 32'(grayscale_o), 32'd149);
    drive(1'b1, 8'd0, 8'd0, 8'd0);
    check("blue_gray", 32'(grayscale_o), 32'd29);
    drive(1'b1, 8'd128, 8'd128, 8'd128);
    check("black_gray", 32'(grayscale_o), 32'd0);
    check("black_done", 32'(done_o), 32'd1);
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    check("mid_gray", 32'(grayscale_o), 32'd128);

    // Bubble: 1,0,1 with junk colour on the idle cycle
    drive(1'b0, 8'hA5, 8'h5A, 8'hC3);
    check("white_gray", 32'(grayscale_o), 32'd255);
    check("white_done", 32'(done_o), 32'd1);
    drive(1'b1, 8'd0, 8'd255, 8'd0);
    check("bubble_done", 32'(done_o), 32'd0);
    check("bubble_hold", 32'(grayscale_o), 32'd255);
    drive(1'b0, 8'h3C, 8'hF0, 8'h0F);
    check("after_bubble_done", 32'(done_o), 32'd1);
    check("after_bubble_gray", 32'(grayscale_o), 32'd149);

    // Random stream, done_i held high
    prev = 0;
    for (int i = 0; i < 4096; i++) begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      drive(1'b1, 8'(r), 8'(g), 8'(b));
      if (i > 0) begin
        check("rand_gray", 32'(grayscale_o), 32'(prev));
        check("rand_done", 32'(done_o), 32'd1);
      end
      prev = golden(r, g, b);
    end

    // Asynchronous reset between edges with the pipeline full
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gray", 32'(grayscale_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_done", 32'(done_o), 32'd0);
    done_i = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check("no_stale_done", 32'(done_o), 32'd0);
      check("no_stale_gray", 32'(grayscale_o), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
